mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter: WAIT_TIMEOUT, default 15, number of consecutive mem_ready-low wait cycles before mem_fault.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-high reset; single clock domain.
REQ-004 op  input  7  opcode of the instruction register.
REQ-005 funct3  input  3  instruction funct3.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access completes this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_write  output  1 each  write enables.
REQ-010 adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 alu_src_a  output  2  00 = PC, 01 = OldPC, 10 = rs1.
REQ-012 alu_src_b  output  2  00 = rs2, 01 = ImmExt, 10 = constant 4.
REQ-013 result_src  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-015 imm_src  output  2  00 I, 01 S, 10 B, 11 J; combinational from op in all states.
REQ-016 instr_done  output  1  one-cycle pulse on each return to FETCH.
REQ-017 mem_fault  output  1  sticky timeout flag.

Function
REQ-018 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, HALT; outputs are Moore-decoded from the state, gated only by mem_ready and zero as stated below.
REQ-019 FETCH: adr_src=0, a=00, b=10, add, result_src=10; ir_write=pc_write=mem_ready; hold while mem_ready=0; move to DECODE on mem_ready=1.
REQ-020 DECODE: a=01, b=01, add; next state: lw 0000011 or sw 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; any other opcode is illegal.
REQ-021 MEMADR: a=10, b=01, add; op[5]=0 -> MEMREAD, op[5]=1 -> MEMWRITE.
REQ-022 MEMREAD: adr_src=1, result_src=00; hold until mem_ready=1, then MEMWB.
REQ-023 MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-024 MEMWRITE: adr_src=1, result_src=00, mem_write=1 held until the mem_ready=1 cycle -> FETCH.
REQ-025 EXECR: a=10, b=00, alu_ctrl from the ALU decoder -> ALUWB; EXECI: a=10, b=01, decoder output -> ALUWB.
REQ-026 ALUWB: result_src=00, reg_write=1 -> FETCH.
REQ-027 BEQ: a=10, b=00, sub, result_src=00, pc_write=zero -> FETCH.
REQ-028 JAL: a=01, b=10, add, result_src=00, pc_write=1 -> ALUWB.
REQ-029 ALU decode: funct3 000 -> sub if op[5]&funct7b5, else add; 010 slt; 110 or; 111 and; any other funct3 -> add.
REQ-030 Timing: FETCH, MEMREAD and MEMWRITE wait states SHALL count cycles with mem_ready=0; the counter clears on state exit. When the count reaches WAIT_TIMEOUT, mem_fault is set, all write enables are 0 that cycle, and the next state is HALT.
REQ-031 Latency with mem_ready=1 throughout: lw 5 cycles, sw 4, R/I 4, beq 3, jal 4.
REQ-032 HALT: all write enables 0; HALT persists until reset; instr_done never asserts in HALT.

Reset
REQ-033 Reset SHALL put the state in FETCH and clear the wait counter and mem_fault asynchronously; all write enables and instr_done are 0 while reset is high.
REQ-034 Reset asserted mid-instruction SHALL abandon it with no further write enables; fetch restarts on the first edge after deassertion.

Configuration
REQ-035 Macro MC_ILLEGAL_TRAP_EN defined: an illegal opcode in DECODE goes to HALT and sets sticky output illegal_instr (1 bit, cleared by reset).
REQ-036 Macro undefined: an illegal opcode returns to FETCH as a no-op with instr_done pulsed; the illegal_instr port does not exist.

Structure
REQ-037 Package riscv_mc_pkg SHALL hold the state enum, opcode constants, alu_ctrl codes, and the src_a, src_b and result_src encodings.
REQ-038 The ALU decode SHALL be sub-module mc_aludec; everything else stays in mc_control_fsm.

Verification
REQ-039 add x3,x1,x2 (op 0110011, funct3 000, f7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; reg_write=1 in cycle 4 only; alu_ctrl=000 in EXECR.
REQ-040 lw with mem_ready low for 3 cycles in MEMREAD -> MEMWB entered 3 cycles late; reg_write asserts exactly once.
REQ-041 beq with zero=1, then with zero=0 -> pc_write=1 in BEQ for the first, pc_write=0 for the second; both 3 cycles.
REQ-042 mem_ready held 0 in FETCH for 15 cycles -> mem_fault=1, HALT, no ir_write; reset clears mem_fault and returns to FETCH.
REQ-043 op 1111111 -> HALT with illegal_instr=1 when MC_ILLEGAL_TRAP_EN is defined; otherwise return to FETCH with instr_done=1.
REQ-044 reset asserted during MEMWRITE with mem_ready=0 -> mem_write drops immediately; state is FETCH after release.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM:
// state enum, opcodes, ALU control codes and datapath mux selects.
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

    function automatic logic op_legal(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
               (op == OP_ITYPE) || (op == OP_BRANCH) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mc_control_fsm_aludec.sv
// ALU decoder: maps funct3/funct7b5 (and op bit 5 to tell R from I) to alu_ctrl.
module mc_aludec
    import riscv_mc_pkg::*;
(
    input  logic       op_b5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  alu_ctrl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle RISC-V main controller with memory wait timeout and sticky fault.
// Define MC_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT (adds illegal_instr).
module mc_control_fsm #(
    parameter int WAIT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_ctrl,
    output logic [1:0] imm_src,
    output logic       instr_done,
    output logic       mem_fault
`ifdef MC_ILLEGAL_TRAP_EN
    ,
    output logic       illegal_instr
`endif
);
    import riscv_mc_pkg::*;

    // state    | meaning
    // FETCH    | read instr, PC+4      DECODE   | decode, branch target
    // MEMADR   | load/store address    MEMREAD  | wait for load data
    // MEMWB    | write load data       MEMWRITE | store until mem_ready
    // EXECR    | reg-reg ALU op        EXECI    | reg-imm ALU op
    // ALUWB    | write ALU result      BEQ      | compare, branch on zero
    // JAL      | link + jump           HALT     | stopped until reset

    localparam int CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WAIT_RELOAD = CNT_W'(WAIT_TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_left;
    logic [2:0]       dec_alu_ctrl;
    logic             wait_state;
    logic             timeout;

    mc_aludec u_aludec (
        .op_b5    (op[5]),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_ctrl (dec_alu_ctrl)
    );

    // wait_left is the number of further low mem_ready cycles tolerated
    assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    assign timeout    = wait_state && !mem_ready && (wait_left == '0);
    assign imm_src    = imm_sel(op);

    always_comb begin
        state_next = state;
        case (state)
            FETCH:    state_next = timeout ? HALT : (mem_ready ? DECODE : FETCH);
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_RTYPE:          state_next = EXECR;
                    OP_ITYPE:          state_next = EXECI;
                    OP_BRANCH:         state_next = BEQ;
                    OP_JAL:            state_next = JAL;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:           state_next = HALT;
`else
                    default:           state_next = FETCH;
`endif
                endcase
            end
            MEMADR:   state_next = op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = timeout ? HALT : (mem_ready ? MEMWB : MEMREAD);
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = timeout ? HALT : (mem_ready ? FETCH : MEMWRITE);
            EXECR:    state_next = ALUWB;
            EXECI:    state_next = ALUWB;
            ALUWB:    state_next = FETCH;
            BEQ:      state_next = FETCH;
            JAL:      state_next = ALUWB;
            HALT:     state_next = HALT;
            default:  state_next = FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        result_src = RES_ALUOUT;
        alu_ctrl   = ALU_ADD;
        case (state)
            FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
            end
            DECODE: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
            end
            MEMADR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            MEMREAD:  adr_src = 1'b1;
            MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            EXECR: begin
                alu_src_a = SRC_A_RS1;
                alu_ctrl  = dec_alu_ctrl;
            end
            EXECI: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_ctrl  = dec_alu_ctrl;
            end
            ALUWB:    reg_write = 1'b1;
            BEQ: begin
                alu_src_a = SRC_A_RS1;
                alu_ctrl  = ALU_SUB;
                pc_write  = zero;
            end
            JAL: begin
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_FOUR;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
        // FETCH decodes to ir_write=mem_ready even while reset holds the state
        if (reset || timeout) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_write = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            wait_left  <= WAIT_RELOAD;
            mem_fault  <= 1'b0;
            instr_done <= 1'b0;
`ifdef MC_ILLEGAL_TRAP_EN
            illegal_instr <= 1'b0;
`endif
        end else begin
            state      <= state_next;
            mem_fault  <= mem_fault | timeout;
            instr_done <= (state_next == FETCH) && (state != FETCH);
            if (wait_state && !mem_ready && (wait_left != '0))
                wait_left <= wait_left - CNT_W'(1);
            else
                wait_left <= WAIT_RELOAD;
`ifdef MC_ILLEGAL_TRAP_EN
            if ((state == DECODE) && !op_legal(op))
                illegal_instr <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction cycle scripts built
// from the instruction-level behaviour, directed cases plus randomized programs.
module tb_mc_control_fsm;
    localparam int WT = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_write, ir_write, reg_write, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_ctrl;
    logic       instr_done, mem_fault;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    mc_control_fsm #(.WAIT_TIMEOUT(WT)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_ctrl   (alu_ctrl),
        .imm_src    (imm_src),
        .instr_done (instr_done),
        .mem_fault  (mem_fault)
`ifdef MC_ILLEGAL_TRAP_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       rdy;
        logic [3:0] we;       // {pc_write, ir_write, reg_write, mem_write}
        logic       chk_alu;
        logic [1:0] a, b;
        logic [2:0] alu;
        logic       chk_adr;
        logic       adr;
        logic       chk_res;
        logic [1:0] res;
    } exp_t;

    exp_t  q[$];
    logic  done_next = 1'b0;
    string cur_test = "none";
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BR = 7'b1100011, JL = 7'b1101111;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic exp_t st(string tag, logic rdy, logic [3:0] we);
        exp_t e;
        e.tag = tag; e.rdy = rdy; e.we = we;
        e.chk_alu = 1'b0; e.a = 2'b00; e.b = 2'b00; e.alu = 3'b000;
        e.chk_adr = 1'b0; e.adr = 1'b0; e.chk_res = 1'b0; e.res = 2'b00;
        return e;
    endfunction

    function automatic exp_t w_alu(exp_t e, logic [1:0] a, logic [1:0] b, logic [2:0] alu);
        exp_t r = e;
        r.chk_alu = 1'b1; r.a = a; r.b = b; r.alu = alu;
        return r;
    endfunction

    function automatic exp_t w_res(exp_t e, logic chk_adr, logic adr, logic [1:0] res);
        exp_t r = e;
        r.chk_adr = chk_adr; r.adr = adr; r.chk_res = 1'b1; r.res = res;
        return r;
    endfunction

    // Arithmetic op the instruction asks for, straight from the funct fields.
    function automatic logic [2:0] ref_alu(logic [6:0] o, logic [2:0] f3, logic f7);
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && o == RT && f7) return 3'b001;
        return 3'b000;
    endfunction

    function automatic logic [1:0] ref_imm(logic [6:0] o);
        if (o == SW) return 2'b01;
        if (o == BR) return 2'b10;
        if (o == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic is_legal(logic [6:0] o);
        return (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BR) || (o == JL);
    endfunction

    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic z, input int fw, input int mw);
        exp_t fe;
        exp_t wb;
        logic [2:0] dec;
        dec = ref_alu(o, f3, f7);
        fe = w_res(w_alu(st("fetch", 1'b0, 4'b0000), 2'b00, 2'b10, 3'b000), 1'b1, 1'b0, 2'b10);
        wb = w_res(st("aluwb", rb(), 4'b0010), 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < fw; i++) q.push_back(fe);
        fe.rdy = 1'b1; fe.we = 4'b1100;
        q.push_back(fe);
        q.push_back(w_alu(st("decode", rb(), 4'b0000), 2'b01, 2'b01, 3'b000));
        case (o)
            LW, SW: begin
                q.push_back(w_alu(st("memadr", rb(), 4'b0000), 2'b10, 2'b01, 3'b000));
                for (int i = 0; i <= mw; i++)
                    q.push_back(w_res(st(o == LW ? "memread" : "memwrite", i == mw,
                                         o == LW ? 4'b0000 : 4'b0001), 1'b1, 1'b1, 2'b00));
                if (o == LW) q.push_back(w_res(st("memwb", rb(), 4'b0010), 1'b0, 1'b0, 2'b01));
            end
            RT: begin
                q.push_back(w_alu(st("execr", rb(), 4'b0000), 2'b10, 2'b00, dec));
                q.push_back(wb);
            end
            IT: begin
                q.push_back(w_alu(st("execi", rb(), 4'b0000), 2'b10, 2'b01, dec));
                q.push_back(wb);
            end
            BR: q.push_back(w_res(w_alu(st("beq", rb(), {z, 3'b000}), 2'b10, 2'b00, 3'b001),
                                  1'b0, 1'b0, 2'b00));
            JL: begin
                q.push_back(w_res(w_alu(st("jal", rb(), 4'b1000), 2'b01, 2'b10, 3'b000),
                                  1'b0, 1'b0, 2'b00));
                q.push_back(wb);
            end
            default: ;
        endcase
    endtask

    // Entered and left at a falling edge, first cycle of the scripted sequence.
    task automatic play(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        exp_t e;
        logic exp_done;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int k = 0; k < q.size(); k++) begin
            e = q[k];
            mem_ready = e.rdy;
            #1;
            exp_done = (k == 0) ? done_next : 1'b0;
            n_cmp++;
            if ({pc_write, ir_write, reg_write, mem_write} !== e.we) begin
                n_bad++;
                $display("FAIL %s/%s c%0d write_en: actual %b required %b", cur_test, e.tag, k,
                         {pc_write, ir_write, reg_write, mem_write}, e.we);
            end
            n_cmp++;
            if (instr_done !== exp_done) begin
                n_bad++;
                $display("FAIL %s/%s c%0d instr_done: actual %b required %b", cur_test, e.tag, k,
                         instr_done, exp_done);
            end
            n_cmp++;
            if (imm_src !== ref_imm(o) || mem_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL %s/%s c%0d imm_src/mem_fault: actual %b/%b required %b/0", cur_test,
                         e.tag, k, imm_src, mem_fault, ref_imm(o));
            end
            if (e.chk_alu) begin
                n_cmp++;
                if ({alu_src_a, alu_src_b, alu_ctrl} !== {e.a, e.b, e.alu}) begin
                    n_bad++;
                    $display("FAIL %s/%s c%0d a/b/alu: actual %b/%b/%b required %b/%b/%b", cur_test,
                             e.tag, k, alu_src_a, alu_src_b, alu_ctrl, e.a, e.b, e.alu);
                end
            end
            if (e.chk_adr) begin
                n_cmp++;
                if (adr_src !== e.adr) begin
                    n_bad++;
                    $display("FAIL %s/%s c%0d adr_src: actual %b required %b", cur_test, e.tag, k,
                             adr_src, e.adr);
                end
            end
            if (e.chk_res) begin
                n_cmp++;
                if (result_src !== e.res) begin
                    n_bad++;
                    $display("FAIL %s/%s c%0d result_src: actual %b required %b", cur_test, e.tag,
                             k, result_src, e.res);
                end
            end
`ifdef MC_ILLEGAL_TRAP_EN
            n_cmp++;
            if (illegal_instr !== 1'b0) begin
                n_bad++;
                $display("FAIL %s/%s c%0d illegal_instr: actual %b required 0", cur_test, e.tag,
                         k, illegal_instr);
            end
`endif
            @(negedge clk);
        end
        q.delete();
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        build(o, f3, f7, z, fw, mw);
        play(o, f3, f7, z);
        done_next = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ir_write, reg_write, mem_write, instr_done, mem_fault} !== 6'b0) begin
            n_bad++;
            $display("FAIL %s/in_reset we,done,fault: actual %b required 000000", cur_test,
                     {pc_write, ir_write, reg_write, mem_write, instr_done, mem_fault});
        end
        @(negedge clk);
        reset = 1'b0;
        done_next = 1'b0;
    endtask

    task automatic halt_checks(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            mem_ready = rb();
            #1;
            n_cmp++;
            if ({pc_write, ir_write, reg_write, mem_write, instr_done} !== 5'b0) begin
                n_bad++;
                $display("FAIL %s/halt c%0d we,done: actual %b required 00000", cur_test, i,
                         {pc_write, ir_write, reg_write, mem_write, instr_done});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        cur_test = "reset";
        do_reset();
    endtask

    task automatic test_basic();
        cur_test = "add";     run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
        cur_test = "sub";     run_instr(RT, 3'b000, 1'b1, 1'b0, 0, 0);
        cur_test = "lw_wait"; run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 3);
        cur_test = "beq_z1";  run_instr(BR, 3'b000, 1'b0, 1'b1, 0, 0);
        cur_test = "beq_z0";  run_instr(BR, 3'b000, 1'b0, 1'b0, 0, 0);
        cur_test = "jal";     run_instr(JL, 3'b000, 1'b0, 1'b0, 0, 0);
        cur_test = "sw";      run_instr(SW, 3'b010, 1'b0, 1'b0, 0, 0);
        cur_test = "addi_f7"; run_instr(IT, 3'b000, 1'b1, 1'b0, 0, 0);
        cur_test = "ori";     run_instr(IT, 3'b110, 1'b0, 1'b0, 1, 0);
        cur_test = "and";     run_instr(RT, 3'b111, 1'b0, 1'b0, 0, 0);
        cur_test = "slti";    run_instr(IT, 3'b010, 1'b0, 1'b0, 0, 0);
        cur_test = "xor_add"; run_instr(RT, 3'b100, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_wait_boundary();
        cur_test = "fetch_wait14"; run_instr(RT, 3'b000, 1'b0, 1'b0, WT - 1, 0);
        cur_test = "lw_wait14";    run_instr(LW, 3'b010, 1'b0, 1'b0, WT - 1, WT - 1);
        cur_test = "sw_wait14";    run_instr(SW, 3'b010, 1'b0, 1'b0, 0, WT - 1);
    endtask

    task automatic test_illegal();
        cur_test = "illegal";
`ifdef MC_ILLEGAL_TRAP_EN
        build(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
        play(7'b1111111, 3'b000, 1'b0, 1'b0);
        n_cmp++;
        if (illegal_instr !== 1'b1) begin
            n_bad++;
            $display("FAIL illegal/trap illegal_instr: actual %b required 1", illegal_instr);
        end
        halt_checks(3);
        do_reset();
        n_cmp++;
        if (illegal_instr !== 1'b0) begin
            n_bad++;
            $display("FAIL illegal/after_reset illegal_instr: actual %b required 0", illegal_instr);
        end
`else
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
`endif
        cur_test = "after_illegal";
        run_instr(RT, 3'b110, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_random();
        logic [6:0] o;
        int kind, fw, mw;
        cur_test = "random";
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            case (kind)
                0: o = LW;
                1: o = SW;
                2: o = RT;
                3: o = IT;
                4: o = BR;
                5: o = JL;
                default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                    o = RT;
`else
                    o = 7'b1111111;
                    for (int t = 0; t < 20; t++) begin
                        o = 7'($urandom);
                        if (!is_legal(o)) break;
                    end
                    if (is_legal(o)) o = 7'b1111111;
`endif
                end
            endcase
            fw = ($urandom_range(0, 7) == 0) ? WT - 1 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? WT - 1 : $urandom_range(0, 3);
            run_instr(o, 3'($urandom), rb(), rb(), fw, mw);
        end
    endtask

    task automatic test_fault_fetch();
        cur_test = "fault_fetch";
        do_reset();
        for (int i = 0; i < WT; i++) begin
            mem_ready = 1'b0;
            #1;
            n_cmp++;
            if ({pc_write, ir_write} !== 2'b00 || mem_fault !== 1'b0) begin
                n_bad++;
                $display("FAIL fault_fetch/wait c%0d pc,ir,fault: actual %b%b%b required 000", i,
                         pc_write, ir_write, mem_fault);
            end
            @(negedge clk);
        end
        #1;
        n_cmp++;
        if (mem_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_fetch/flag mem_fault: actual %b required 1", mem_fault);
        end
        halt_checks(4);
        n_cmp++;
        if (mem_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_fetch/sticky mem_fault: actual %b required 1", mem_fault);
        end
        do_reset();
        cur_test = "after_fault";
        run_instr(RT, 3'b000, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_fault_memwrite();
        exp_t e;
        cur_test = "fault_memwrite";
        do_reset();
        build(SW, 3'b010, 1'b0, 1'b0, 0, WT - 1);
        e = q.pop_back();
        e.rdy = 1'b0;
        e.we = 4'b0000;
        e.tag = "memwrite_timeout";
        q.push_back(e);
        play(SW, 3'b010, 1'b0, 1'b0);
        #1;
        n_cmp++;
        if (mem_fault !== 1'b1) begin
            n_bad++;
            $display("FAIL fault_memwrite/flag mem_fault: actual %b required 1", mem_fault);
        end
        halt_checks(3);
        do_reset();
        cur_test = "after_fault_mw";
        run_instr(IT, 3'b111, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset_midwrite();
        cur_test = "reset_midwrite";
        do_reset();
        build(SW, 3'b010, 1'b0, 1'b0, 0, 2);
        void'(q.pop_back());
        play(SW, 3'b010, 1'b0, 1'b0);
        mem_ready = 1'b0;
        #1;
        n_cmp++;
        if (mem_write !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_midwrite/before mem_write: actual %b required 1", mem_write);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ir_write, reg_write, mem_write} !== 4'b0) begin
            n_bad++;
            $display("FAIL reset_midwrite/async write_en: actual %b required 0000",
                     {pc_write, ir_write, reg_write, mem_write});
        end
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({pc_write, ir_write, reg_write, mem_write, instr_done} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_midwrite/held we,done: actual %b required 00000",
                     {pc_write, ir_write, reg_write, mem_write, instr_done});
        end
        @(negedge clk);
        reset = 1'b0;
        done_next = 1'b0;
        cur_test = "after_midwrite";
        run_instr(LW, 3'b010, 1'b0, 1'b0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_wait_boundary();
        test_illegal();
        test_random();
        test_fault_fetch();
        test_fault_memwrite();
        test_reset_midwrite();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
